// File: rtl/uart_axil_pkg.sv
// Shared AXI4-Lite response codes, engine state encodings and default
// UART-Lite register offsets for the UART bridge.
package uart_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] DEF_RX_ADDR   = 32'h0;
    localparam logic [31:0] DEF_TX_ADDR   = 32'h4;
    localparam logic [31:0] DEF_STAT_ADDR = 32'h8;

    typedef enum logic [1:0] {
        W_IDLE,
        W_REQ,
        W_RESP
    } wr_state_e;

    typedef enum logic [2:0] {
        R_IDLE,
        R_STAT,
        R_STATW,
        R_DATA,
        R_DATAW
    } rd_state_e;

    // Only the two error codes have bit 1 set; OKAY/EXOKAY count as success.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; the head entry is readable
// combinationally so a consumer can latch it the cycle after the push.
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              push_ok;
    logic              pop_ok;

    always_comb begin
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        pop_ok   = pop && !empty;
        // A pop in the same cycle frees the slot, so a push while full still lands.
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    assign head = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/uart_axil_bridge.sv
// Core-strobe to AXI4-Lite UART-Lite bridge: a FIFO-fed write engine and an
// independent status-polling read engine, each with bounded error retry.
module uart_axil_bridge
    import uart_axil_pkg::*;
#(
    parameter int          DATA_W       = 32,
    parameter int          TX_DEPTH     = 8,
    parameter logic [31:0] RX_ADDR      = DEF_RX_ADDR,
    parameter logic [31:0] TX_ADDR      = DEF_TX_ADDR,
    parameter logic [31:0] STAT_ADDR    = DEF_STAT_ADDR,
    parameter int          RX_VALID_BIT = 0,
    parameter int          MAX_RETRY    = 3
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                wenable,
    input  logic [DATA_W-1:0]   wdata,
    output logic                tx_full,
    output logic                tx_empty,
    output logic                wdone,
    output logic                werr,
    input  logic                renable,
    output logic                rdone,
    output logic [DATA_W-1:0]   rdata,
    output logic                rerr,
    output logic [31:0]         uart_awaddr,
    output logic                uart_awvalid,
    input  logic                uart_awready,
    output logic [DATA_W-1:0]   uart_wdata,
    output logic [DATA_W/8-1:0] uart_wstrb,
    output logic                uart_wvalid,
    input  logic                uart_wready,
    input  logic [1:0]          uart_bresp,
    input  logic                uart_bvalid,
    output logic                uart_bready,
    output logic [31:0]         uart_araddr,
    output logic                uart_arvalid,
    input  logic                uart_arready,
    input  logic [DATA_W-1:0]   uart_rdata,
    input  logic [1:0]          uart_rresp,
    input  logic                uart_rvalid,
    output logic                uart_rready
);

    localparam int                STRB_W    = DATA_W / 8;
    localparam logic [STRB_W-1:0] WSTRB_LSB = STRB_W'(1);
    localparam int                CNT_W     = $clog2(MAX_RETRY + 2);
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_RETRY);

    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (wenable),
        .push_data (wdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    wr_state_e         w_state_q, w_state_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic              wdone_q, wdone_d;
    logic              werr_q, werr_d;

    rd_state_e         r_state_q, r_state_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic [31:0]       araddr_q, araddr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  rcnt_q, rcnt_d;
    logic              rdone_q, rdone_d;
    logic              rerr_q, rerr_d;

    // Write engine: the FIFO entry stays put until its final response so a
    // retry re-sends the latched copy without touching the FIFO.
    always_comb begin
        w_state_d = w_state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        wdata_d   = wdata_q;
        wcnt_d    = wcnt_q;
        wdone_d   = 1'b0;
        werr_d    = 1'b0;
        fifo_pop  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (!fifo_empty) begin
                    wdata_d   = fifo_head;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    wcnt_d    = '0;
                    w_state_d = W_REQ;
                end
            end
            W_REQ: begin
                if (awvalid_q && uart_awready) awvalid_d = 1'b0;
                if (wvalid_q && uart_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d  = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (uart_bvalid) begin
                    bready_d = 1'b0;
                    if (!resp_is_err(uart_bresp)) begin
                        fifo_pop  = 1'b1;
                        wdone_d   = 1'b1;
                        w_state_d = W_IDLE;
                    end else if (wcnt_q < MAX_CNT) begin
                        wcnt_d    = wcnt_q + CNT_W'(1);
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        w_state_d = W_REQ;
                    end else begin
                        fifo_pop  = 1'b1;
                        werr_d    = 1'b1;
                        w_state_d = W_IDLE;
                    end
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read engine: "no data yet" status re-polls forever without consuming
    // retries; only error responses count against MAX_RETRY.
    always_comb begin
        r_state_d = r_state_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        araddr_d  = araddr_q;
        rdata_d   = rdata_q;
        rcnt_d    = rcnt_q;
        rdone_d   = 1'b0;
        rerr_d    = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (renable) begin
                    araddr_d  = STAT_ADDR;
                    arvalid_d = 1'b1;
                    rcnt_d    = '0;
                    r_state_d = R_STAT;
                end
            end
            R_STAT, R_DATA: begin
                if (uart_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    r_state_d = (r_state_q == R_STAT) ? R_STATW : R_DATAW;
                end
            end
            R_STATW: begin
                if (uart_rvalid) begin
                    rready_d = 1'b0;
                    if (resp_is_err(uart_rresp)) begin
                        if (rcnt_q < MAX_CNT) begin
                            rcnt_d    = rcnt_q + CNT_W'(1);
                            arvalid_d = 1'b1;
                            r_state_d = R_STAT;
                        end else begin
                            rerr_d    = 1'b1;
                            r_state_d = R_IDLE;
                        end
                    end else if (uart_rdata[RX_VALID_BIT]) begin
                        araddr_d  = RX_ADDR;
                        arvalid_d = 1'b1;
                        rcnt_d    = '0;
                        r_state_d = R_DATA;
                    end else begin
                        arvalid_d = 1'b1;
                        r_state_d = R_STAT;
                    end
                end
            end
            R_DATAW: begin
                if (uart_rvalid) begin
                    rready_d = 1'b0;
                    if (!resp_is_err(uart_rresp)) begin
                        rdata_d   = uart_rdata;
                        rdone_d   = 1'b1;
                        r_state_d = R_IDLE;
                    end else if (rcnt_q < MAX_CNT) begin
                        rcnt_d    = rcnt_q + CNT_W'(1);
                        arvalid_d = 1'b1;
                        r_state_d = R_DATA;
                    end else begin
                        rerr_d    = 1'b1;
                        r_state_d = R_IDLE;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_q <= W_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            wdata_q   <= '0;
            wcnt_q    <= '0;
            wdone_q   <= 1'b0;
            werr_q    <= 1'b0;
            r_state_q <= R_IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            araddr_q  <= STAT_ADDR;
            rdata_q   <= '0;
            rcnt_q    <= '0;
            rdone_q   <= 1'b0;
            rerr_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            wdata_q   <= wdata_d;
            wcnt_q    <= wcnt_d;
            wdone_q   <= wdone_d;
            werr_q    <= werr_d;
            r_state_q <= r_state_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            araddr_q  <= araddr_d;
            rdata_q   <= rdata_d;
            rcnt_q    <= rcnt_d;
            rdone_q   <= rdone_d;
            rerr_q    <= rerr_d;
        end
    end

    assign tx_full      = fifo_full;
    assign tx_empty     = fifo_empty && (w_state_q == W_IDLE);
    assign wdone        = wdone_q;
    assign werr         = werr_q;
    assign rdone        = rdone_q;
    assign rdata        = rdata_q;
    assign rerr         = rerr_q;
    assign uart_awaddr  = TX_ADDR;
    assign uart_awvalid = awvalid_q;
    assign uart_wdata   = wdata_q;
    assign uart_wstrb   = WSTRB_LSB;
    assign uart_wvalid  = wvalid_q;
    assign uart_bready  = bready_q;
    assign uart_araddr  = araddr_q;
    assign uart_arvalid = arvalid_q;
    assign uart_rready  = rready_q;

endmodule

// File: tb/tb_uart_axil_bridge.sv
// Directed and randomized bench for uart_axil_bridge against a behavioural
// AXI4-Lite UART slave and a per-word attempt model.
module tb_uart_axil_bridge;

    localparam int          MAX_RETRY = 3;
    localparam int          DEPTH     = 8;
    localparam logic [31:0] RXA       = 32'h0;
    localparam logic [31:0] TXA       = 32'h4;
    localparam logic [31:0] STA       = 32'h8;
    localparam logic [1:0]  OKAY      = 2'b00;
    localparam logic [1:0]  SLVERR    = 2'b10;

    logic        clk = 1'b0;
    logic        rstn;
    logic        wenable, renable;
    logic [31:0] wdata;
    logic        tx_full, tx_empty, wdone, werr, rdone, rerr;
    logic [31:0] rdata;
    logic [31:0] awaddr, araddr, uwdata, urdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    uart_axil_bridge #(
        .DATA_W(32), .TX_DEPTH(DEPTH), .RX_ADDR(RXA), .TX_ADDR(TXA),
        .STAT_ADDR(STA), .RX_VALID_BIT(0), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rstn(rstn),
        .wenable(wenable), .wdata(wdata), .tx_full(tx_full), .tx_empty(tx_empty),
        .wdone(wdone), .werr(werr),
        .renable(renable), .rdone(rdone), .rdata(rdata), .rerr(rerr),
        .uart_awaddr(awaddr), .uart_awvalid(awvalid), .uart_awready(awready),
        .uart_wdata(uwdata), .uart_wstrb(wstrb), .uart_wvalid(wvalid), .uart_wready(wready),
        .uart_bresp(bresp), .uart_bvalid(bvalid), .uart_bready(bready),
        .uart_araddr(araddr), .uart_arvalid(arvalid), .uart_arready(arready),
        .uart_rdata(urdata), .uart_rresp(rresp), .uart_rvalid(rvalid), .uart_rready(rready)
    );

    int n_vec = 0;
    int n_err = 0;

    // Slave control (written by the stimulus) and scripted responses.
    logic        stall_en = 1'b0;
    logic        hold_aw = 1'b0, hold_b = 1'b0, hold_r = 1'b0;
    logic [1:0]  bresp_q[$];
    logic [33:0] stat_q[$];
    logic [33:0] rx_q[$];

    // Slave-side observation logs (written by the slave only).
    logic [31:0] wlog_addr[$];
    logic [31:0] wlog_data[$];
    logic [3:0]  wlog_strb[$];
    logic [31:0] rlog_addr[$];
    int          stab_viol = 0;
    int          n_wdone = 0, n_werr = 0, n_rdone = 0, n_rerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural AXI4-Lite UART slave, evaluated once per cycle at negedge.
    initial begin : axi_slave
        logic        aw_got, w_got, ar_got, b_fire, r_fire;
        logic        aw_wait, w_wait, ar_wait;
        logic [31:0] cap_aw, cap_w, cap_ar, hold_awa, hold_wd, hold_ara;
        logic [3:0]  cap_strb;
        logic [33:0] e;
        int          b_idx, s_idx, x_idx;
        b_idx = 0; s_idx = 0; x_idx = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        awready = 0; wready = 0; arready = 0;
        bvalid = 0; bresp = OKAY; rvalid = 0; rresp = OKAY; urdata = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0;
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            end else begin
                if (aw_wait && !(awvalid && awaddr == hold_awa)) stab_viol++;
                if (w_wait && !(wvalid && uwdata == hold_wd)) stab_viol++;
                if (ar_wait && !(arvalid && araddr == hold_ara)) stab_viol++;
                if (b_fire) begin bvalid = 0; b_fire = 0; end
                if (aw_got && w_got && !bvalid && !hold_b) begin
                    wlog_addr.push_back(cap_aw);
                    wlog_data.push_back(cap_w);
                    wlog_strb.push_back(cap_strb);
                    if (b_idx < bresp_q.size()) begin bresp = bresp_q[b_idx]; b_idx++; end
                    else bresp = OKAY;
                    bvalid = 1; aw_got = 0; w_got = 0;
                end
                awready = hold_aw ? 1'b0 : (stall_en ? ($urandom_range(0, 1) == 1) : 1'b1);
                wready  = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (awvalid && awready && !aw_got) begin aw_got = 1; cap_aw = awaddr; end
                if (wvalid && wready && !w_got) begin w_got = 1; cap_w = uwdata; cap_strb = wstrb; end
                aw_wait = awvalid && !awready; hold_awa = awaddr;
                w_wait  = wvalid && !wready;   hold_wd  = uwdata;
                b_fire  = bvalid && bready;

                if (r_fire) begin rvalid = 0; r_fire = 0; end
                if (ar_got && !rvalid && !hold_r) begin
                    rlog_addr.push_back(cap_ar);
                    if (cap_ar == STA) begin
                        if (s_idx < stat_q.size()) begin e = stat_q[s_idx]; s_idx++; end
                        else e = {OKAY, 32'h1};
                    end else if (cap_ar == RXA) begin
                        if (x_idx < rx_q.size()) begin e = rx_q[x_idx]; x_idx++; end
                        else e = {OKAY, 32'hDEAD_BEEF};
                    end else e = '0;
                    {rresp, urdata} = e;
                    rvalid = 1; ar_got = 0;
                end
                arready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (arvalid && arready && !ar_got) begin ar_got = 1; cap_ar = araddr; end
                ar_wait = arvalid && !arready; hold_ara = araddr;
                r_fire  = rvalid && rready;
            end
        end
    end

    initial begin : pulse_monitor
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (wdone) n_wdone++;
                if (werr)  n_werr++;
                if (rdone) n_rdone++;
                if (rerr)  n_rerr++;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic push_word(input logic [31:0] d);
        wenable = 1'b1;
        wdata   = d;
        @(negedge clk);
        wenable = 1'b0;
    endtask

    task automatic wait_tx_idle(input string tag);
        int i;
        i = 0;
        while (!tx_empty && i < 3000) begin @(negedge clk); i++; end
        chk({tag, "_tx_timeout"}, 64'(i < 3000), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_rd(input string tag, input int pd, input int pe);
        int i;
        i = 0;
        while (n_rdone == pd && n_rerr == pe && i < 3000) begin @(negedge clk); i++; end
        chk({tag, "_rd_timeout"}, 64'(i < 3000), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_writes(input string tag, input int base, input logic [31:0] exp[$]);
        chk({tag, "_wcount"}, 64'(wlog_data.size() - base), 64'(exp.size()));
        for (int i = 0; i < exp.size() && base + i < wlog_data.size(); i++) begin
            chk($sformatf("%s_waddr%0d", tag, i), 64'(wlog_addr[base+i]), 64'(TXA));
            chk($sformatf("%s_wdata%0d", tag, i), 64'(wlog_data[base+i]), 64'(exp[i]));
            chk($sformatf("%s_wstrb%0d", tag, i), 64'(wlog_strb[base+i]), 64'h1);
        end
    endtask

    task automatic chk_reads(input string tag, input int base, input logic [31:0] exp[$]);
        chk({tag, "_rcount"}, 64'(rlog_addr.size() - base), 64'(exp.size()));
        for (int i = 0; i < exp.size() && base + i < rlog_addr.size(); i++)
            chk($sformatf("%s_raddr%0d", tag, i), 64'(rlog_addr[base+i]), 64'(exp[i]));
    endtask

    initial begin : stimulus
        int          bw, br, pd, pe, prd, pre, nw, k, errs, i;
        logic [31:0] d, rxd;
        logic [31:0] exp_w[$];
        logic [31:0] exp_r[$];

        rstn = 1'b0; wenable = 1'b0; renable = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_tx_full", 64'(tx_full), 64'd0);
        chk("rst_tx_empty", 64'(tx_empty), 64'd1);
        chk("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
        chk("rst_pulses", 64'({wdone, werr, rdone, rerr}), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_awaddr", 64'(awaddr), 64'(TXA));
        chk("rst_araddr", 64'(araddr), 64'(STA));
        chk("rst_wstrb", 64'(wstrb), 64'h1);

        // 1: three back-to-back pushes, zero-wait OKAY slave
        bw = wlog_data.size(); pd = n_wdone;
        push_word(32'h41); push_word(32'h42); push_word(32'h43);
        wait_tx_idle("t1");
        exp_w = '{32'h41, 32'h42, 32'h43};
        chk_writes("t1", bw, exp_w);
        chk("t1_wdone", 64'(n_wdone - pd), 64'd3);
        chk("t1_tx_empty", 64'(tx_empty), 64'd1);

        // 2: fill with awready held low; the ninth push is dropped
        hold_aw = 1'b1;
        @(negedge clk);
        bw = wlog_data.size(); pd = n_wdone;
        for (int j = 0; j < DEPTH; j++) begin
            push_word(32'h100 + 32'(j));
            if (j == DEPTH - 2) chk("t2_full_before", 64'(tx_full), 64'd0);
        end
        chk("t2_full_after", 64'(tx_full), 64'd1);
        push_word(32'h1FF);
        repeat (5) @(negedge clk);
        chk("t2_still_full", 64'(tx_full), 64'd1);
        chk("t2_no_write_held", 64'(wlog_data.size() - bw), 64'd0);
        hold_aw = 1'b0;
        wait_tx_idle("t2");
        exp_w.delete();
        for (int j = 0; j < DEPTH; j++) exp_w.push_back(32'h100 + 32'(j));
        chk_writes("t2", bw, exp_w);
        chk("t2_wdone", 64'(n_wdone - pd), 64'(DEPTH));

        // 3a: two SLVERR then OKAY -> three identical writes, one wdone
        bw = wlog_data.size(); pd = n_wdone; pe = n_werr;
        bresp_q.push_back(SLVERR); bresp_q.push_back(SLVERR); bresp_q.push_back(OKAY);
        push_word(32'h55);
        wait_tx_idle("t3a");
        exp_w = '{32'h55, 32'h55, 32'h55};
        chk_writes("t3a", bw, exp_w);
        chk("t3a_wdone", 64'(n_wdone - pd), 64'd1);
        chk("t3a_werr", 64'(n_werr - pe), 64'd0);

        // 3b: retries exhausted -> werr once, following word proceeds
        bw = wlog_data.size(); pd = n_wdone; pe = n_werr;
        for (int j = 0; j <= MAX_RETRY; j++) bresp_q.push_back(SLVERR);
        push_word(32'h66); push_word(32'h67);
        wait_tx_idle("t3b");
        exp_w.delete();
        for (int j = 0; j <= MAX_RETRY; j++) exp_w.push_back(32'h66);
        exp_w.push_back(32'h67);
        chk_writes("t3b", bw, exp_w);
        chk("t3b_werr", 64'(n_werr - pe), 64'd1);
        chk("t3b_wdone", 64'(n_wdone - pd), 64'd1);

        // 4: status 0,0,1 then RX word 0x7A
        br = rlog_addr.size(); prd = n_rdone; pre = n_rerr;
        stat_q.push_back({OKAY, 32'h0}); stat_q.push_back({OKAY, 32'hFFFF_FFFE});
        stat_q.push_back({OKAY, 32'h1}); rx_q.push_back({OKAY, 32'h7A});
        renable = 1'b1; @(negedge clk); renable = 1'b0;
        wait_rd("t4", prd, pre);
        exp_r = '{STA, STA, STA, RXA};
        chk_reads("t4", br, exp_r);
        chk("t4_rdone", 64'(n_rdone - prd), 64'd1);
        chk("t4_rdata", 64'(rdata), 64'h7A);

        // 4b: status read errors beyond the retry budget -> rerr, no rdone
        br = rlog_addr.size(); prd = n_rdone; pre = n_rerr;
        for (int j = 0; j <= MAX_RETRY; j++) stat_q.push_back({SLVERR, 32'h1});
        renable = 1'b1; @(negedge clk); renable = 1'b0;
        wait_rd("t4b", prd, pre);
        exp_r.delete();
        for (int j = 0; j <= MAX_RETRY; j++) exp_r.push_back(STA);
        chk_reads("t4b", br, exp_r);
        chk("t4b_rerr", 64'(n_rerr - pre), 64'd1);
        chk("t4b_rdone", 64'(n_rdone - prd), 64'd0);
        chk("t4b_rdata_held", 64'(rdata), 64'h7A);

        // 5: concurrent randomized traffic with random ready stalls
        stall_en = 1'b1;
        for (int it = 0; it < 8; it++) begin
            bw = wlog_data.size(); br = rlog_addr.size();
            pd = n_wdone; pe = n_werr; prd = n_rdone; pre = n_rerr;
            exp_w.delete(); exp_r.delete();
            nw = $urandom_range(1, 4);
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) begin
                stat_q.push_back({OKAY, $urandom() & 32'hFFFF_FFFE});
                exp_r.push_back(STA);
            end
            stat_q.push_back({OKAY, $urandom() | 32'h1});
            exp_r.push_back(STA);
            exp_r.push_back(RXA);
            rxd = $urandom();
            rx_q.push_back({OKAY, rxd});
            pd = pd; errs = 0;
            for (int w = 0; w < nw; w++) begin
                d = $urandom();
                k = ($urandom_range(0, 2) == 0) ? $urandom_range(1, MAX_RETRY + 1) : 0;
                for (int j = 0; j < k; j++) bresp_q.push_back(SLVERR);
                if (k <= MAX_RETRY) bresp_q.push_back(OKAY);
                else errs++;
                for (int j = 0; j < ((k <= MAX_RETRY) ? k + 1 : MAX_RETRY + 1); j++)
                    exp_w.push_back(d);
                if (w == 0) begin
                    renable = 1'b1; wenable = 1'b1; wdata = d;
                    @(negedge clk);
                    renable = 1'b0; wenable = 1'b0;
                end else push_word(d);
            end
            i = 0;
            while ((!tx_empty || n_rdone == prd) && i < 5000) begin @(negedge clk); i++; end
            chk($sformatf("t5_%0d_timeout", it), 64'(i < 5000), 64'd1);
            repeat (3) @(negedge clk);
            chk_writes($sformatf("t5_%0d", it), bw, exp_w);
            chk_reads($sformatf("t5_%0d", it), br, exp_r);
            chk($sformatf("t5_%0d_wdone", it), 64'(n_wdone - pd), 64'(nw - errs));
            chk($sformatf("t5_%0d_werr", it), 64'(n_werr - pe), 64'(errs));
            chk($sformatf("t5_%0d_rdata", it), 64'(rdata), 64'(rxd));
        end
        chk("t5_valid_stable", 64'(stab_viol), 64'd0);
        stall_en = 1'b0;

        // 6: asynchronous reset mid-W_RESP and mid-R_STATW
        hold_b = 1'b1; hold_r = 1'b1;
        @(negedge clk);
        pd = n_wdone; prd = n_rdone;
        renable = 1'b1; wenable = 1'b1; wdata = 32'h99;
        @(negedge clk);
        renable = 1'b0; wenable = 1'b0;
        i = 0;
        while (!(bready && rready) && i < 200) begin @(negedge clk); i++; end
        chk("t6_reach_wait_states", 64'(i < 200), 64'd1);
        #2 rstn = 1'b0;
        #1;
        chk("t6_valids_low", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
        chk("t6_fifo_empty", 64'({tx_empty, tx_full}), 64'b10);
        chk("t6_rdata_cleared", 64'(rdata), 64'd0);
        hold_b = 1'b0; hold_r = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        chk("t6_no_wdone", 64'(n_wdone - pd), 64'd0);
        chk("t6_no_rdone", 64'(n_rdone - prd), 64'd0);
        chk("t6_idle_after", 64'({awvalid, arvalid, tx_empty}), 64'b001);
        chk("t6_valid_stable", 64'(stab_viol), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_axil_bridge.md
Name: uart_axil_bridge

Overview:
Bridges the core's single-cycle UART request strobes to an AXI4-Lite UART peripheral (UART-Lite register map).
- Write side: a TX FIFO lets the core push bytes back-to-back without stalling. A write engine drains the FIFO one AXI write at a time, with bounded retry on error responses.
- Read side: a receive engine polls the status register until RX data is available, then reads the RX register and returns the data.
- The write and read engines run concurrently and independently. The block sits between the core's IO unit and the UART IP.

Parameters:
DATA_W, 32, AXI data width and core data width (multiple of 8)
TX_DEPTH, 8, TX FIFO entries (power of 2, ≥2)
RX_ADDR, 32'h0, RX FIFO register address
TX_ADDR, 32'h4, TX FIFO register address
STAT_ADDR, 32'h8, status register address
RX_VALID_BIT, 0, status bit meaning "RX data valid"
MAX_RETRY, 3, re-issues allowed after an error response (0 = none)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
wenable  in  1  push wdata into TX FIFO
wdata  in  DATA_W  data to transmit
tx_full  out  1  TX FIFO full; a push while full is dropped
tx_empty  out  1  TX FIFO empty and write engine idle
wdone  out  1  one-cycle pulse: one entry written with OKAY
werr  out  1  one-cycle pulse: entry discarded after retries exhausted
renable  in  1  request one received word
rdone  out  1  one-cycle pulse: rdata valid
rdata  out  DATA_W  received word, held until next rdone
rerr  out  1  one-cycle pulse: read aborted after retries exhausted
uart_awaddr/awvalid/awready, uart_wdata/wstrb/wvalid/wready, uart_bresp/bvalid/bready  AXI4-Lite write channels (out/out/in, out/out/out/in, in/in/out)
uart_araddr/arvalid/arready, uart_rdata/rresp/rvalid/rready  AXI4-Lite read channels (out/out/in, in/in/in/out)

Behaviour:
- Reset (async, all flops):
  - all valid/ready outputs 0; wdone, werr, rdone, rerr 0
  - FIFO emptied; tx_full 0, tx_empty 1; rdata 0
  - uart_awaddr=TX_ADDR, uart_araddr=STAT_ADDR
  - uart_wstrb: LSB byte lane only (all lanes 0 except bit 0)
  - a reset mid-transaction abandons it with no completion pulse.
- TX FIFO:
  - a push (wenable && !tx_full) is visible to the write engine the next cycle
  - push and pop in the same cycle leave the count unchanged; a push while full is accepted in that cycle
  - pointers are log2(TX_DEPTH) bits plus a wrap bit; wrap-around is seamless.
- Write engine states: W_IDLE, W_REQ, W_RESP.
  - W_IDLE→W_REQ when FIFO non-empty: uart_wdata←head, awvalid=wvalid=1, retry count←0.
  - In W_REQ, awvalid and wvalid each drop on their own handshake in either order. Both done→W_RESP with bready=1.
  - W_RESP on bvalid: bready←0.
    - bresp[1]==0: pop, wdone pulse, →W_IDLE.
    - Error with count<MAX_RETRY: count+1, →W_REQ with the same data.
    - Error otherwise: pop, werr pulse, →W_IDLE.
  - Minimum throughput: one entry per 4 cycles with zero-wait slave.
- Read engine states: R_IDLE, R_STAT, R_STATW, R_DATA, R_DATAW.
  - R_IDLE on renable: araddr←STAT_ADDR, arvalid=1, →R_STAT.
  - arvalid drops on arready; then rready=1, →R_STATW.
  - On rvalid, rready←0.
    - Error resp, count<MAX_RETRY: re-poll.
    - Error resp, retries exhausted: rerr, →R_IDLE.
    - uart_rdata[RX_VALID_BIT]==1: araddr←RX_ADDR, →R_DATA.
    - Otherwise re-poll immediately; polling is unbounded, is not an error and does not count as a retry.
  - R_DATA/R_DATAW use the same handshake. OKAY → rdata←uart_rdata, rdone pulse, →R_IDLE; errors retry R_DATA per MAX_RETRY.
  - renable while not R_IDLE is ignored (no queueing).
- All outputs are registered; no combinational path from AXI inputs to outputs.

Decomposition:
- Package uart_axil_pkg holds:
  - the AXI response codes (OKAY=2'b00, SLVERR=2'b10)
  - the write and read state enums
  - default register offsets.
- Sub-module sync_fifo (DATA_W, DEPTH), reusable elsewhere, for the TX FIFO; both engines stay in the top level.

Test Plan:
1. Push 3 words 0x41,0x42,0x43 on consecutive cycles, slave zero-wait OKAY → three AXI writes to 0x4 in order, three wdone pulses, tx_empty returns 1.
2. Push TX_DEPTH+1 words with awready held 0 → tx_full=1 after the 8th push, 9th word dropped; release awready → exactly 8 writes, 8 wdone.
3. Slave returns SLVERR twice then OKAY for word 0x55 → three identical writes of 0x55, one wdone, no werr; with MAX_RETRY+1 errors → werr once, next word proceeds.
4. renable with status reads 0,0,1 then RX read 0x7A → three reads at 0x8, one at 0x0, rdone with rdata=0x7A.
5. Concurrent: renable and wenable the same cycle, awready/arready randomly stalled → both complete independently, AXI valid held stable until handshake.
6. Assert rstn=0 asynchronously mid-W_RESP and mid-R_STATW → all valids/readies low immediately, FIFO empty, no wdone/rdone after release.
